layered_color_mapper: RTL and testbench
=======================================

Name: layered_color_mapper

Overview:
Parametrised, pipelined successor to the fixed ball/wall color mapper. Resolves N_LAYERS prioritized object-hit flags, each carrying a palette index, into one 24-bit RGB pixel via a run-time writable palette. Pixels with no winning layer get the purple gradient background. Adds a per-frame brightness fade engine. Sits between the object/sprite generators and the VGA output registers.

Parameters:
N_LAYERS, 4, number of object layers; layer 0 has highest priority
IDX_W, 4, palette index width; palette depth 2**IDX_W
COLOR_W, 8, bits per color channel
CLIP_Y, 352, first DrawY row at which clipped layers are suppressed
CLIP_MASK, 4'b0010, bit i=1 means layer i is clipped at CLIP_Y (default clips the wall layer)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
pix_valid  in  1  DrawX/DrawY/layer inputs valid this cycle
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
layer_hit  in  N_LAYERS  bit i=1 means layer i covers the pixel
layer_idx  in  N_LAYERS*IDX_W  palette index of layer i, at bits [i*IDX_W +: IDX_W]
pal_we  in  1  palette write strobe
pal_addr  in  IDX_W  palette write address
pal_data  in  3*COLOR_W  write data, packed {R,G,B}
frame_start  in  1  one-cycle pulse at the start of vertical blank
fade_en  in  1  fade engine steps on frame_start while high
fade_dir  in  1  1 = fade toward dark, 0 = fade toward full brightness
VGA_R  out  COLOR_W  red
VGA_G  out  COLOR_W  green
VGA_B  out  COLOR_W  blue
out_valid  out  1  RGB outputs correspond to a valid pixel
fade_level  out  $clog2(COLOR_W+1)  current right-shift applied to every channel
fade_done  out  1  fade_level is at the limit selected by fade_dir

Behaviour:
- Reset, synchronous, active-high: VGA_R/G/B=0, out_valid=0, fade_level=0, pipeline valids=0. fade_done is combinational and equals 1 at reset, because fade_level=0 and fade_dir=0 at reset.
- Reset also reloads the palette defaults: entry 0=000000, entry 1=FFFF00 (yellow), entry 2=0000FF (blue), all others=000000.
- Stage 1, registered:
  - eff_hit[i] = layer_hit[i] & ~(CLIP_MASK[i] & (DrawY >= CLIP_Y)).
  - Winner = lowest i with eff_hit[i]=1.
  - Register any_hit, the winner's index, DrawX[9:3] and pix_valid.
- Stage 2, registered:
  - If any_hit, color = palette[idx]. Otherwise R=8'h3F, G=0, B=8'h7F - {1'b0, DrawX[9:3]} (8-bit modular), each scaled to COLOR_W by left-justifying.
  - Each channel is then shifted right by fade_level; a shift of COLOR_W yields 0.
  - out_valid = stage-1 valid.
- Latency is exactly 2 Clk from pix_valid/DrawX sample to VGA_*/out_valid. Throughput is 1 pixel/cycle with no stalls.
- When pix_valid=0 the stage still advances; out_valid goes 0 two cycles later and RGB outputs are forced to 0, which gives a clean blanking level.
- Palette: single write port, read by stage 2. A write in cycle t becomes visible to a stage-2 read in cycle t+1. A same-cycle read of the same address returns the old value. The write address is IDX_W bits wide, so there is no out-of-range case.
- Fade engine, a saturating counter that updates only on cycles where frame_start=1 and fade_en=1:
  - fade_dir=1: fade_level += 1, saturating at COLOR_W.
  - fade_dir=0: fade_level -= 1, saturating at 0.
- fade_done = (fade_dir ? fade_level==COLOR_W : fade_level==0), combinational.
- fade_en or fade_dir changes take effect on the next frame_start. The fade_level used for a pixel is its value at the stage-2 capture edge.
- Reset asserted mid-pipeline: in-flight pixels are discarded, outputs are 0 on the following cycle, and palette writes made before the reset are lost.
- When several layers hit, only the priority winner counts; lower-priority indices are ignored. If all hits are clipped away, the pixel shows background.

Decomposition:
- Package color_mapper_pkg:
  - rgb_t struct {r,g,b}, each logic [7:0]
  - BG_R=8'h3F, BG_G=8'h00, BG_B_BASE=8'h7F
  - default palette constants PAL_YELLOW, PAL_BLUE, PAL_BLACK
  - function prio_encode(hit vector) returning {any, index}
- Sub-module palette_ram (IDX_W, COLOR_W): synchronous write, combinational read, synchronous reset to the package defaults.
- The fade counter and the two pipeline stages stay in the top module.

Test Plan:
- Reset then pix_valid=1, DrawX=0, DrawY=0, layer_hit=0 -> after 2 cycles RGB=3F/00/7F, out_valid=1. With DrawX=80 -> B=7F-0A=75.
- layer_hit=4'b0110, idx1=2, idx2=1, DrawY=100 -> RGB=0000FF (layer 1 wins). With DrawY=352 -> layer 1 clipped, RGB=FFFF00 from layer 2. With DrawY=400 and layer_hit=4'b0010 only -> background.
- Write pal_addr=3, pal_data=12_34_56 in the same cycle stage 2 reads idx 3 -> that output shows 000000; the next pixel using idx 3 shows 123456.
- fade_en=1, fade_dir=1, 9 frame_start pulses with idx1 (FFFF00) displayed -> fade_level 1..8 then holds at 8. R steps FF,7F,3F,...,00; fade_done=1 after the 8th pulse. Then fade_dir=0 with 8 pulses -> back to 0, fade_done=1.
- Toggle pix_valid 1,0,1 -> out_valid 1,0,1 delayed 2 cycles; RGB=0 while out_valid=0.
- Assert Reset during a streaming burst at fade_level=3 with palette entry 5 written -> next cycle outputs 0, fade_level=0, entry 5 reads 000000, entry 1 reads FFFF00.

Source files
------------

// File: rtl/color_mapper_pkg.sv
// Shared types, constants and helpers for the layered color mapper.
package color_mapper_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Background gradient: blue falls off as DrawX increases.
  localparam logic [7:0] BG_R      = 8'h3F;
  localparam logic [7:0] BG_G      = 8'h00;
  localparam logic [7:0] BG_B_BASE = 8'h7F;

  localparam rgb_t PAL_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t PAL_YELLOW = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t PAL_BLUE   = '{r: 8'h00, g: 8'h00, b: 8'hFF};

  // Widest hit vector the priority encoder accepts.
  localparam int unsigned MAX_LAYERS = 32;

  typedef struct packed {
    logic       any;
    logic [4:0] idx;
  } prio_t;

  // Lowest set bit wins; idx is 0 when nothing is set.
  function automatic prio_t prio_encode(input logic [MAX_LAYERS-1:0] hit);
    prio_t res;
    res = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        res.any = 1'b1;
        res.idx = i[4:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Run-time writable palette: synchronous write, combinational read,
// synchronous reset back to the power-on colors.
module palette_ram
  import color_mapper_pkg::*;
#(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned COLOR_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [3*COLOR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]     raddr_i,
  output logic [3*COLOR_W-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << IDX_W;

  logic [3*COLOR_W-1:0] mem_q [Depth];

  // Left-justify an 8-bit channel into COLOR_W bits (truncate or zero-pad).
  function automatic logic [COLOR_W-1:0] chan_scale(input logic [7:0] c);
    logic [COLOR_W-1:0] o;
    o = '0;
    for (int k = 0; k < int'(COLOR_W); k++) begin
      if (k < 8) o[COLOR_W-1-k] = c[3'(7 - k)];
    end
    return o;
  endfunction

  function automatic logic [3*COLOR_W-1:0] rgb_scale(input rgb_t c);
    return {chan_scale(c.r), chan_scale(c.g), chan_scale(c.b)};
  endfunction

  // Reset reloads defaults and takes priority over a pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (i == 1)      mem_q[i] <= rgb_scale(PAL_YELLOW);
        else if (i == 2) mem_q[i] <= rgb_scale(PAL_BLUE);
        else             mem_q[i] <= rgb_scale(PAL_BLACK);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the pre-write contents in the cycle of a write.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/layered_color_mapper.sv
// Two-stage pixel pipeline: priority-resolve object layers, then look up the
// palette (or background gradient) and apply the per-frame fade shift.
module layered_color_mapper
  import color_mapper_pkg::*;
#(
  parameter int unsigned          N_LAYERS  = 4,
  parameter int unsigned          IDX_W     = 4,
  parameter int unsigned          COLOR_W   = 8,
  parameter int unsigned          CLIP_Y    = 352,
  parameter logic [N_LAYERS-1:0]  CLIP_MASK = N_LAYERS'(4'b0010),
  localparam int unsigned         FL_W      = $clog2(COLOR_W + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      pix_valid,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [N_LAYERS-1:0]       layer_hit,
  input  logic [N_LAYERS*IDX_W-1:0] layer_idx,
  input  logic                      pal_we,
  input  logic [IDX_W-1:0]          pal_addr,
  input  logic [3*COLOR_W-1:0]      pal_data,
  input  logic                      frame_start,
  input  logic                      fade_en,
  input  logic                      fade_dir,
  output logic [COLOR_W-1:0]        VGA_R,
  output logic [COLOR_W-1:0]        VGA_G,
  output logic [COLOR_W-1:0]        VGA_B,
  output logic                      out_valid,
  output logic [FL_W-1:0]           fade_level,
  output logic                      fade_done
);

  localparam logic [9:0]      ClipRow = CLIP_Y[9:0];
  localparam logic [FL_W-1:0] FadeMax = FL_W'(COLOR_W);

  // ---------------- Stage 1: clip and priority resolve ----------------
  logic                      y_clip;
  logic [N_LAYERS-1:0]       eff_hit;
  prio_t                     win;
  logic [IDX_W-1:0]          s1_idx_d;
  logic                      s1_valid_q, s1_any_q;
  logic [IDX_W-1:0]          s1_idx_q;
  logic [6:0]                s1_x_q;
  logic                      unused_drawx;

  assign unused_drawx = ^DrawX[2:0];

  // Drop clipped layers below the clip row, then pick the winner's palette index.
  always_comb begin
    y_clip   = (DrawY >= ClipRow);
    eff_hit  = layer_hit & ~(CLIP_MASK & {N_LAYERS{y_clip}});
    win      = prio_encode(MAX_LAYERS'(eff_hit));
    s1_idx_d = '0;
    for (int i = 0; i < int'(N_LAYERS); i++) begin
      if (win.idx == 5'(i)) s1_idx_d = layer_idx[i*IDX_W +: IDX_W];
    end
  end

  // Stage-1 registers; the stage advances every cycle, valid or not.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_x_q     <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      s1_any_q   <= win.any;
      s1_idx_q   <= s1_idx_d;
      s1_x_q     <= DrawX[9:3];
    end
  end

  // ---------------- Palette ----------------
  logic [3*COLOR_W-1:0] pal_rdata;

  palette_ram #(
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_palette (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_data),
    .raddr_i (s1_idx_q),
    .rdata_o (pal_rdata)
  );

  // ---------------- Fade engine ----------------
  logic [FL_W-1:0] fade_d, fade_q;

  // Saturating step, only on an enabled frame_start.
  always_comb begin
    fade_d = fade_q;
    if (frame_start && fade_en) begin
      if (fade_dir) begin
        if (fade_q != FadeMax) fade_d = fade_q + 1'b1;
      end else begin
        if (fade_q != '0) fade_d = fade_q - 1'b1;
      end
    end
  end

  // Fade level register.
  always_ff @(posedge Clk) begin
    if (Reset) fade_q <= '0;
    else       fade_q <= fade_d;
  end

  assign fade_level = fade_q;
  assign fade_done  = fade_dir ? (fade_q == FadeMax) : (fade_q == '0);

  // ---------------- Stage 2: color select and fade ----------------
  function automatic logic [COLOR_W-1:0] chan_scale(input logic [7:0] c);
    logic [COLOR_W-1:0] o;
    o = '0;
    for (int k = 0; k < int'(COLOR_W); k++) begin
      if (k < 8) o[COLOR_W-1-k] = c[3'(7 - k)];
    end
    return o;
  endfunction

  function automatic logic [COLOR_W-1:0] fade_shift(input logic [COLOR_W-1:0] c,
                                                     input logic [FL_W-1:0]    s);
    return (s >= FadeMax) ? '0 : (c >> s);
  endfunction

  logic [7:0]         bg_b;
  logic [COLOR_W-1:0] base_r, base_g, base_b;
  logic [COLOR_W-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic               valid_q;

  // Palette color or gradient, faded; blanked to 0 for invalid pixels.
  always_comb begin
    bg_b = BG_B_BASE - {1'b0, s1_x_q};
    if (s1_any_q) begin
      base_r = pal_rdata[3*COLOR_W-1 -: COLOR_W];
      base_g = pal_rdata[2*COLOR_W-1 -: COLOR_W];
      base_b = pal_rdata[COLOR_W-1:0];
    end else begin
      base_r = chan_scale(BG_R);
      base_g = chan_scale(BG_G);
      base_b = chan_scale(bg_b);
    end
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (s1_valid_q) begin
      r_d = fade_shift(base_r, fade_q);
      g_d = fade_shift(base_g, fade_q);
      b_d = fade_shift(base_b, fade_q);
    end
  end

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      valid_q <= s1_valid_q;
    end
  end

  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Scoreboard bench for layered_color_mapper: the driver pushes expected pixels
// computed from a behavioural model, the monitor pops on out_valid.
module tb_layered_color_mapper;

  logic        Clk = 1'b0;
  logic        Reset, pix_valid, pal_we, frame_start, fade_en, fade_dir;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  layer_hit, pal_addr;
  logic [15:0] layer_idx;
  logic [23:0] pal_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid, fade_done;
  logic [3:0]  fade_level;

  layered_color_mapper dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .layer_hit   (layer_hit),
    .layer_idx   (layer_idx),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .frame_start (frame_start),
    .fade_en     (fade_en),
    .fade_dir    (fade_dir),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .out_valid   (out_valid),
    .fade_level  (fade_level),
    .fade_done   (fade_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } exp_t;

  exp_t        q[$];
  logic [23:0] m_pal [16];
  int          m_fade;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = 24'h000000;
    m_pal[1] = 24'hFFFF00;
    m_pal[2] = 24'h0000FF;
    m_fade = 0;
  endfunction

  // Highest-priority unclipped layer picks a palette entry, else gradient.
  function automatic logic [23:0] model_pix(input logic [9:0] x, input logic [9:0] y,
                                            input logic [3:0] hit, input logic [15:0] idxv);
    int          sel = -1;
    logic [7:0]  r, g, b;
    logic [3:0]  pi;
    for (int i = 0; i < 4; i++)
      if (sel < 0 && hit[i] && !(i == 1 && y >= 10'd352)) sel = i;
    if (sel >= 0) begin
      pi = 4'((idxv >> (4 * sel)) & 16'hF);
      {r, g, b} = m_pal[pi];
    end else begin
      r = 8'h3F;
      g = 8'h00;
      b = 8'h7F - 8'(x / 8);
    end
    if (m_fade >= 8) return 24'h0;
    return {8'(r >> m_fade), 8'(g >> m_fade), 8'(b >> m_fade)};
  endfunction

  // One cycle of stimulus; model updates mirror what the pixel will observe.
  task automatic step(input logic v, input logic [9:0] x, input logic [9:0] y,
                      input logic [3:0] hit, input logic [15:0] idxv,
                      input logic we, input logic [3:0] wa, input logic [23:0] wd,
                      input logic fs, input logic fen, input logic fdir, input logic rst);
    @(negedge Clk);
    Reset = rst; pix_valid = v; DrawX = x; DrawY = y; layer_hit = hit; layer_idx = idxv;
    pal_we = we; pal_addr = wa; pal_data = wd;
    frame_start = fs; fade_en = fen; fade_dir = fdir;
    if (rst) begin
      model_reset();
      q.delete();
    end else begin
      if (we) m_pal[wa] = wd;
      if (fs && fen) m_fade = fdir ? ((m_fade < 8) ? m_fade + 1 : 8)
                                  : ((m_fade > 0) ? m_fade - 1 : 0);
      if (v) q.push_back('{due: cyc + 2, rgb: model_pix(x, y, hit, idxv)});
    end
  endtask

  task automatic px(input logic v, input logic [9:0] x, input logic [9:0] y,
                    input logic [3:0] hit, input logic [15:0] idxv);
    step(v, x, y, hit, idxv, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0, fade_dir, 1'b0);
  endtask

  task automatic fade_px(input logic fs, input logic fdir);
    step(1'b1, 10'd0, 10'd0, 4'b0010, 16'h0010, 1'b0, 4'd0, 24'd0, fs, 1'b1, fdir, 1'b0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      if (cyc >= 2) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_valid", 32'(out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e.rgb});
          end
        end else begin
          chk("blank_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'd0);
          if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_valid", 32'(out_valid), 32'd1);
            void'(q.pop_front());
          end
        end
        chk("fade_level", 32'(fade_level), m_fade);
        chk("fade_done", 32'(fade_done), fade_dir ? 32'(m_fade == 8) : 32'(m_fade == 0));
      end
    end
  end

  initial begin
    Reset = 1'b1; pix_valid = 0; DrawX = 0; DrawY = 0; layer_hit = 0; layer_idx = 0;
    pal_we = 0; pal_addr = 0; pal_data = 0; frame_start = 0; fade_en = 0; fade_dir = 0;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Background gradient.
    px(1, 10'd0, 10'd0, 4'b0000, 16'h0000);
    px(1, 10'd80, 10'd0, 4'b0000, 16'h0000);
    px(1, 10'd1023, 10'd0, 4'b0000, 16'h0000);

    // Priority and clipping around the clip row.
    px(1, 10'd5, 10'd100, 4'b0110, 16'h0120);
    px(1, 10'd5, 10'd351, 4'b0110, 16'h0120);
    px(1, 10'd5, 10'd352, 4'b0110, 16'h0120);
    px(1, 10'd5, 10'd400, 4'b0010, 16'h0020);
    px(1, 10'd5, 10'd400, 4'b1111, 16'h2222);

    // Palette write racing a stage-2 read of the same entry.
    px(1, 10'd0, 10'd0, 4'b0001, 16'h0003);
    step(1, 10'd0, 10'd0, 4'b0001, 16'h0003, 1, 4'd3, 24'h123456, 0, 0, 0, 0);
    px(1, 10'd0, 10'd0, 4'b0001, 16'h0003);

    // Fade toward dark (one pulse past saturation), then back.
    for (int k = 0; k < 9; k++) begin
      fade_px(1, 1);
      fade_px(0, 1);
    end
    for (int k = 0; k < 8; k++) begin
      fade_px(1, 0);
      fade_px(0, 0);
    end

    // Valid toggling gives blanking.
    px(1, 10'd16, 10'd0, 4'b0000, 16'h0000);
    px(0, 10'd16, 10'd0, 4'b0000, 16'h0000);
    px(1, 10'd24, 10'd0, 4'b0000, 16'h0000);

    // Reset during a burst with fade and a written entry.
    for (int k = 0; k < 3; k++) fade_px(1, 1);
    step(1, 10'd0, 10'd0, 4'b0001, 16'h0005, 1, 4'd5, 24'hABCDEF, 0, 0, 1, 0);
    px(1, 10'd0, 10'd0, 4'b0001, 16'h0005);
    px(1, 10'd0, 10'd0, 4'b0001, 16'h0005);
    step(1, 10'd0, 10'd0, 4'b0001, 16'h0005, 0, 4'd0, 24'd0, 0, 0, 1, 1);
    px(1, 10'd0, 10'd0, 4'b0001, 16'h0005);
    px(1, 10'd0, 10'd0, 4'b0001, 16'h0001);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic [9:0] ry;
      ry = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(345, 360))
                                       : 10'($urandom_range(0, 1023));
      step(($urandom_range(0, 3) != 0), 10'($urandom), ry, 4'($urandom), 16'($urandom),
           ($urandom_range(0, 9) == 0), 4'($urandom), 24'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 149) == 0));
    end

    // Drain the pipeline.
    for (int k = 0; k < 4; k++) px(0, 10'd0, 10'd0, 4'b0000, 16'h0000);
    @(negedge Clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
